// File: rtl/bit_serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// Ovf exists only when BIT_SERIAL_SUB_OVERFLOW_EN is defined.
interface bit_serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    logic             Ovf;

    modport master (output start, A, B, input busy, done, Diff, Bout, Ovf);
    modport slave  (input start, A, B, output busy, done, Diff, Bout, Ovf);
`else
    modport master (output start, A, B, input busy, done, Diff, Bout);
    modport slave  (input start, A, B, output busy, done, Diff, Bout);
`endif
endinterface

// File: rtl/bit_serial_subtractor.sv
// LSB-first serial A - B: one full-subtractor cell plus a borrow flop, start/busy/done handshake.
// Optional signed-overflow flag Ovf under BIT_SERIAL_SUB_OVERFLOW_EN.
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    bit_serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic bit_a, bit_b, bit_d, bit_bnext;

    always_comb begin
        bit_a     = a_q[0];
        bit_b     = b_q[0];
        bit_d     = bit_a ^ bit_b ^ borrow_q;
        bit_bnext = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                diff_d   = {bit_d, diff_q[WIDTH-1:1]};
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                borrow_d = bit_bnext;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Operand MSBs have shifted down to bit 0 on this last cycle.
                    bout_d  = bit_bnext;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = (bit_a != bit_b) && (bit_d != bit_a);
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    assign bus.Ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Bench for bit_serial_subtractor: cycle-numbered reference model plus directed literal checks.
module tb_bit_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;

    bit_serial_subtractor_if #(.WIDTH(W)) bus ();

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start at the edge where cyc becomes acc makes busy
    // high for cyc acc..acc+W-1, done high at acc+W, and the next start acceptable at acc+W+2.
    int               acc;
    int               next_ok;
    logic [W-1:0]     pd, ed;
    logic             pb, eb, po, eo;
    logic             exp_busy, exp_done;

    initial begin
        acc = -1; next_ok = 0;
        pd = '0; ed = '0; pb = 0; eb = 0; po = 0; eo = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                acc = -1; next_ok = 0;
                ed = '0; eb = 1'b0; eo = 1'b0;
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_done", 32'(bus.done), 32'd0);
                chk("rst_diff", 32'(bus.Diff), 32'd0);
                chk("rst_bout", 32'(bus.Bout), 32'd0);
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
                chk("rst_ovf", 32'(bus.Ovf), 32'd0);
`endif
            end else begin
                exp_busy = (acc >= 0) && (cyc >= acc) && (cyc <= acc + W - 1);
                exp_done = (acc >= 0) && (cyc == acc + W);
                if (exp_done) begin
                    ed = pd; eb = pb; eo = po;
                end
                chk("busy", 32'(bus.busy), 32'(exp_busy));
                chk("done", 32'(bus.done), 32'(exp_done));
                if (!exp_busy) begin
                    chk("diff", 32'(bus.Diff), 32'(ed));
                    chk("bout", 32'(bus.Bout), 32'(eb));
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
                    chk("ovf", 32'(bus.Ovf), 32'(eo));
`endif
                end
                if (bus.start && (cyc + 1 >= next_ok)) begin
                    int sa, sb, sd;
                    acc     = cyc + 1;
                    next_ok = acc + W + 2;
                    pd      = bus.A - bus.B;
                    pb      = (bus.A < bus.B);
                    sa      = $signed(bus.A);
                    sb      = $signed(bus.B);
                    sd      = sa - sb;
                    po      = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
                end
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.A = W'($urandom); bus.B = W'($urandom);
    endtask

    // Waits (bounded) for done while scrambling A/B every cycle.
    task automatic wait_done(input string name, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            bus.A = W'($urandom); bus.B = W'($urandom);
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, W + 4);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] xd, input logic xb, input logic xo);
        bit seen;
        start_op(a, b);
        wait_done(name, seen);
        if (seen) begin
            chk({name, "_diff"}, 32'(bus.Diff), 32'(xd));
            chk({name, "_bout"}, 32'(bus.Bout), 32'(xb));
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
            chk({name, "_ovf"}, 32'(bus.Ovf), 32'(xo));
`else
            if (xo === 1'bx) $display("unused");
`endif
        end
    endtask

    initial begin
        bit seen;
        cyc = 0; errors = 0; checks = 0;
        reset = 1'b0; bus.start = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        run_op("t5a_23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        run_op("t10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_op("t00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("t80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("t7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op("t33_11", 8'h33, 8'h11, 8'h22, 1'b0, 1'b0);

        // Starts during SHIFT and during the DONE cycle must be ignored.
        start_op(8'h5A, 8'h23);
        repeat (2) @(posedge clk);
        #1 bus.start = 1'b1; bus.A = 8'hFF; bus.B = 8'h01;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (W - 3) @(posedge clk);
        #1 bus.start = 1'b1; bus.A = 8'hFF; bus.B = 8'h01;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("ign_diff", 32'(bus.Diff), 32'h37);
        chk("ign_busy", 32'(bus.busy), 32'd0);
        run_op("tff_01", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);

        // Reset mid-operation aborts at once.
        start_op(8'hFF, 8'h0F);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_diff", 32'(bus.Diff), 32'd0);
        chk("abort_bout", 32'(bus.Bout), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_op("t09_04", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

        // Random operations with start noise and occasional resets; checked by the model.
        for (int n = 0; n < 40; n++) begin
            int gap;
            int rst_at;
            gap    = $urandom_range(0, 3);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, W) : -1;
            repeat (gap) @(posedge clk);
            start_op(W'($urandom), W'($urandom));
            seen = 1'b0;
            for (int i = 0; i < W + 4; i++) begin
                @(posedge clk); #1;
                bus.A = W'($urandom); bus.B = W'($urandom);
                bus.start = ($urandom_range(0, 3) == 0);
                if (i == rst_at) begin
                    reset = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 reset = 1'b1;
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
                if (bus.done) begin
                    seen = 1'b1;
                    break;
                end
            end
            #1 bus.start = 1'b0;
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL rand_timeout: got no done expected done within %0d cycles", W + 4);
            end
            repeat (W + 3) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
- Computes Diff = A − B one bit per clock, LSB first, using a full-subtractor cell and a borrow flip-flop.
- It is the inverse arithmetic partner of the bit-serial adder in the same datapath; the two sit side by side in the serial ALU.
- Adds a start/busy/done handshake so a controller can issue operations back to back without counting cycles externally.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the accepted-start edge only.
- B  input  WIDTH  subtrahend; sampled on the accepted-start edge only.
- busy  output  1  high while the block is shifting (SHIFT state).
- done  output  1  one-cycle pulse when Diff/Bout are valid.
- Diff  output  WIDTH  registered result A − B mod 2^WIDTH.
- Bout  output  1  final borrow (1 when unsigned A < B).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, Diff=0, Bout=0.
  - Operand shift registers, borrow FF and bit counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: load A and B into internal shift registers, borrow FF=0, counter=0, go to SHIFT.
  - With start=0: stay in IDLE. Diff and Bout hold their last values.
- SHIFT (busy=1), every cycle:
  - a=Areg[0], b=Breg[0], br=borrow FF.
  - d = a^b^br.
  - bnext = (~a&b) | (~(a^b)&br).
  - Diff shift register shifts right with d entering at MSB.
  - Areg and Breg shift right with 0 filled in.
  - borrow FF ← bnext; counter++.
  - When the counter reaches WIDTH−1 (the last bit processed), Bout ← bnext and go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0; Diff holds the full result.
  - Return to IDLE next cycle.
- Latency:
  - start accepted at edge k → busy high for cycles k+1..k+WIDTH → done high in cycle k+WIDTH+1.
  - Total WIDTH+1 cycles from accepted start to done.
- Diff is not guaranteed meaningful while busy=1; it is partially shifted. It becomes final at the done cycle and holds until the next accepted start.
- start while in SHIFT or DONE is ignored: no queuing, no restart. A new op requires start in IDLE, so back-to-back throughput is one op per WIDTH+2 cycles.
- A and B may change freely after the accepted-start edge without affecting the running operation.
- reset asserted mid-operation: abort immediately, all outputs return to reset values, no done pulse.
- Arithmetic is modulo 2^WIDTH:
  - A=B gives Diff=0, Bout=0.
  - A<B (unsigned) gives two's-complement wrap with Bout=1.

Optional Feature:
- Macro: BIT_SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - Extra output port Ovf (output, 1), signed overflow flag. Reset value 0.
  - Captured together with Bout on the last SHIFT cycle: Ovf = (a_msb != b_msb) && (d_msb != a_msb).
  - Held until the next accepted start.
- When undefined: port Ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset low then high; start with A=0x5A, B=0x23 → busy for 8 cycles; done pulses in cycle 9 after the start edge; Diff=0x37, Bout=0.
- A=0x10, B=0x20 → Diff=0xF0, Bout=1. A=0x00, B=0x00 → Diff=0x00, Bout=0.
- A=0x80, B=0x01 with BIT_SERIAL_SUB_OVERFLOW_EN → Diff=0x7F, Bout=0, Ovf=1. A=0x7F, B=0xFF → Diff=0x80, Bout=1, Ovf=1.
- Start A=0x5A, B=0x23; pulse start with A=0xFF, B=0x01 at cycles 3 and 9 (DONE) → ignored; result 0x37; the next start in IDLE yields 0xFE.
- Start A=0xFF, B=0x0F; assert reset at cycle 4 → busy=0, Diff=0, Bout=0 immediately, no done. After release, a new start with A=0x09, B=0x04 → Diff=0x05.
- Change A/B every cycle during SHIFT after starting A=0x33, B=0x11 → Diff=0x22, unaffected.
